// File: rtl/pcie_tx_arbiter.sv
// Two-requester arbiter that multiplexes TLP streams onto the PCIe core TX AXI-Stream port.
// Define PCIE_TX_CPL_PRIORITY_EN to give the completion engine (requester 0) strict priority.
module pcie_tx_arbiter #(
    parameter int unsigned MIN_BUF_AV = 2
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic [127:0] rq0_tdata,
    input  logic [15:0]  rq0_tkeep,
    input  logic         rq0_tlast,
    input  logic         rq0_tvalid,
    output logic         rq0_tready,

    input  logic [127:0] rq1_tdata,
    input  logic [15:0]  rq1_tkeep,
    input  logic         rq1_tlast,
    input  logic         rq1_tvalid,
    output logic         rq1_tready,

    output logic [127:0] s_axis_tx_tdata,
    output logic [15:0]  s_axis_tx_tstrb,
    output logic         s_axis_tx_tlast,
    output logic         s_axis_tx_tvalid,
    input  logic         s_axis_tx_tready,
    output logic [3:0]   s_axis_tx_tuser,
    input  logic [5:0]   tx_buf_av,
    output logic [1:0]   grant,
    output logic [15:0]  pkt_cnt0,
    output logic [15:0]  pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    localparam logic [5:0] MinBufAv = 6'(MIN_BUF_AV);

    state_e      state_q, state_d;
    logic [15:0] pktCnt0_q, pktCnt0_d;
    logic [15:0] pktCnt1_q, pktCnt1_d;
    logic        bufOk;
    logic        pick1;

    assign bufOk = (tx_buf_av >= MinBufAv);

`ifdef PCIE_TX_CPL_PRIORITY_EN
    assign pick1 = rq1_tvalid & ~rq0_tvalid;
`else
    // lastServed_q=1 means requester 1 finished the most recent packet, so requester 0 wins a tie.
    logic lastServed_q, lastServed_d;

    assign pick1 = rq1_tvalid & (~rq0_tvalid | ~lastServed_q);
`endif

    always_comb begin
        state_d   = state_q;
        pktCnt0_d = pktCnt0_q;
        pktCnt1_d = pktCnt1_q;
`ifndef PCIE_TX_CPL_PRIORITY_EN
        lastServed_d = lastServed_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bufOk && (rq0_tvalid || rq1_tvalid)) begin
                    state_d = pick1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0: begin
                if (rq0_tvalid && s_axis_tx_tready && rq0_tlast) begin
                    state_d   = IDLE;
                    pktCnt0_d = pktCnt0_q + 16'd1;
`ifndef PCIE_TX_CPL_PRIORITY_EN
                    lastServed_d = 1'b0;
`endif
                end
            end
            BUSY1: begin
                if (rq1_tvalid && s_axis_tx_tready && rq1_tlast) begin
                    state_d   = IDLE;
                    pktCnt1_d = pktCnt1_q + 16'd1;
`ifndef PCIE_TX_CPL_PRIORITY_EN
                    lastServed_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-latency pass-through of the owning requester; everything is quiet while idle.
    always_comb begin
        grant            = 2'b00;
        rq0_tready       = 1'b0;
        rq1_tready       = 1'b0;
        s_axis_tx_tdata  = '0;
        s_axis_tx_tstrb  = '0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        unique case (state_q)
            BUSY0: begin
                grant            = 2'b01;
                rq0_tready       = s_axis_tx_tready;
                s_axis_tx_tdata  = rq0_tdata;
                s_axis_tx_tstrb  = rq0_tkeep;
                s_axis_tx_tlast  = rq0_tlast;
                s_axis_tx_tvalid = rq0_tvalid;
            end
            BUSY1: begin
                grant            = 2'b10;
                rq1_tready       = s_axis_tx_tready;
                s_axis_tx_tdata  = rq1_tdata;
                s_axis_tx_tstrb  = rq1_tkeep;
                s_axis_tx_tlast  = rq1_tlast;
                s_axis_tx_tvalid = rq1_tvalid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pktCnt0_q <= '0;
            pktCnt1_q <= '0;
`ifndef PCIE_TX_CPL_PRIORITY_EN
            lastServed_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            pktCnt0_q <= pktCnt0_d;
            pktCnt1_q <= pktCnt1_d;
`ifndef PCIE_TX_CPL_PRIORITY_EN
            lastServed_q <= lastServed_d;
`endif
        end
    end

    assign s_axis_tx_tuser = 4'b0000;
    assign pkt_cnt0        = pktCnt0_q;
    assign pkt_cnt1        = pktCnt1_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Self-checking bench for pcie_tx_arbiter: cycle-accurate vector table plus a beat scoreboard.
// Expected grant order follows PCIE_TX_CPL_PRIORITY_EN when the bench is built with it.
module tb_pcie_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] rq0_tdata, rq1_tdata;
    logic [15:0]  rq0_tkeep, rq1_tkeep;
    logic         rq0_tlast, rq1_tlast;
    logic         rq0_tvalid, rq1_tvalid;
    logic         rq0_tready, rq1_tready;
    logic [127:0] s_axis_tx_tdata;
    logic [15:0]  s_axis_tx_tstrb;
    logic         s_axis_tx_tlast;
    logic         s_axis_tx_tvalid;
    logic         s_axis_tx_tready;
    logic [3:0]   s_axis_tx_tuser;
    logic [5:0]   tx_buf_av;
    logic [1:0]   grant;
    logic [15:0]  pkt_cnt0, pkt_cnt1;

`ifdef PCIE_TX_CPL_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    always #5 clk = ~clk;

    pcie_tx_arbiter #(.MIN_BUF_AV(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rq0_tdata        (rq0_tdata),
        .rq0_tkeep        (rq0_tkeep),
        .rq0_tlast        (rq0_tlast),
        .rq0_tvalid       (rq0_tvalid),
        .rq0_tready       (rq0_tready),
        .rq1_tdata        (rq1_tdata),
        .rq1_tkeep        (rq1_tkeep),
        .rq1_tlast        (rq1_tlast),
        .rq1_tvalid       (rq1_tvalid),
        .rq1_tready       (rq1_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tstrb  (s_axis_tx_tstrb),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tuser  (s_axis_tx_tuser),
        .tx_buf_av        (tx_buf_av),
        .grant            (grant),
        .pkt_cnt0         (pkt_cnt0),
        .pkt_cnt1         (pkt_cnt1)
    );

    typedef struct {
        logic        rst, v0, l0, v1, l1, rdy;
        logic [5:0]  bufAv;
        logic [1:0]  g;
        logic        t0, t1, ov, ol;
        logic [15:0] c0, c1;
    } vec_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [127:0] mkData(input int n, input int k);
        logic [31:0] w;
        w = 32'(k) ^ ((n == 0) ? 32'hC0DE_0000 : 32'hD1A0_0000);
        return {4{w}};
    endfunction

    function automatic logic [15:0] mkKeep(input int n, input int k);
        return 16'(k * 37 + n * 11 + 1);
    endfunction

    task automatic addVec(input int rst, input int v0, input int l0, input int v1, input int l1,
                          input int rdy, input int bufAv, input int g, input int t0, input int t1,
                          input int ov, input int ol, input int c0, input int c1);
        vec_t v;
        v.rst = 1'(rst); v.v0 = 1'(v0); v.l0 = 1'(l0); v.v1 = 1'(v1); v.l1 = 1'(l1);
        v.rdy = 1'(rdy); v.bufAv = 6'(bufAv); v.g = 2'(g);
        v.t0 = 1'(t0); v.t1 = 1'(t1); v.ov = 1'(ov); v.ol = 1'(ol);
        v.c0 = 16'(c0); v.c1 = 16'(c1);
        vecs.push_back(v);
    endtask

    // Drive one table row and predict the beat the core should see if a handshake is expected.
    task automatic applyStimulus(input vec_t v, input int k);
        beat_t b;
        rst_n            = v.rst;
        rq0_tvalid       = v.v0;
        rq0_tlast        = v.l0;
        rq0_tdata        = mkData(0, k);
        rq0_tkeep        = mkKeep(0, k);
        rq1_tvalid       = v.v1;
        rq1_tlast        = v.l1;
        rq1_tdata        = mkData(1, k);
        rq1_tkeep        = mkKeep(1, k);
        s_axis_tx_tready = v.rdy;
        tx_buf_av        = v.bufAv;
        if (v.ov && v.rdy) begin
            if (v.g == 2'b01) b = '{data: mkData(0, k), keep: mkKeep(0, k), last: v.l0};
            else              b = '{data: mkData(1, k), keep: mkKeep(1, k), last: v.l1};
            sb.push_back(b);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int k);
        logic [41:0] act, exp;
        act = {grant, rq0_tready, rq1_tready, s_axis_tx_tvalid, s_axis_tx_tlast,
               s_axis_tx_tuser, pkt_cnt0, pkt_cnt1};
        exp = {v.g, v.t0, v.t1, v.ov, v.ol, 4'b0000, v.c0, v.c1};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL row%0d {grant,t0,t1,tvalid,tlast,tuser,cnt0,cnt1}: got %h expected %h",
                     k, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream one packet from requester n while the core ready flickers randomly.
    task automatic sendPacket(input int n, input int beats);
        int    sent = 0;
        int    cyc  = 0;
        beat_t b;
        rst_n     = 1'b1;
        tx_buf_av = 6'd8;
        while (sent < beats && cyc < 100) begin
            b = '{data: mkData(n, 1000 + sent), keep: mkKeep(n, 1000 + sent), last: (sent == beats - 1)};
            rq0_tvalid = (n == 0); rq0_tdata = b.data; rq0_tkeep = b.keep; rq0_tlast = b.last;
            rq1_tvalid = (n == 1); rq1_tdata = b.data; rq1_tkeep = b.keep; rq1_tlast = b.last;
            s_axis_tx_tready = 1'($urandom_range(0, 1));
            #1;
            if ((n == 0) ? rq0_tready : rq1_tready) begin
                sb.push_back(b);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rq0_tvalid = 1'b0;
        rq1_tvalid = 1'b0;
        checks++;
        if (sent < beats) begin
            errors++;
            $display("[TB] FAIL sendPacket rq%0d timeout: got %0d beats expected %0d", n, sent, beats);
        end
    endtask

    // Every beat accepted by the core must be the next predicted one.
    always @(negedge clk) begin
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            beat_t got, want;
            got = '{data: s_axis_tx_tdata, keep: s_axis_tx_tstrb, last: s_axis_tx_tlast};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat unexpected: got %h expected none", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL beat: got %h expected %h", got, want);
                end
            end
        end
    end

    initial begin
        // rst v0 l0 v1 l1 rdy buf | grant t0 t1 tvalid tlast cnt0 cnt1
        addVec(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0);
        addVec(1,1,0,0,0,1,8, 0,0,0,0,0, 0,0);
        addVec(1,1,0,0,0,1,8, 1,1,0,1,0, 0,0);
        addVec(1,1,0,0,0,1,8, 1,1,0,1,0, 0,0);
        addVec(1,1,1,0,0,1,8, 1,1,0,1,1, 0,0);
        addVec(1,0,0,0,0,1,8, 0,0,0,0,0, 1,0);
        addVec(1,0,0,1,0,1,1, 0,0,0,0,0, 1,0);
        addVec(1,0,0,1,0,1,1, 0,0,0,0,0, 1,0);
        addVec(1,0,0,1,0,1,2, 0,0,0,0,0, 1,0);
        addVec(1,0,0,1,0,1,0, 2,0,1,1,0, 1,0);
        addVec(1,0,0,1,1,1,0, 2,0,1,1,1, 1,0);
        addVec(1,0,0,1,0,1,8, 0,0,0,0,0, 1,1);
        addVec(1,0,0,1,0,1,8, 2,0,1,1,0, 1,1);
        addVec(1,0,0,1,0,0,8, 2,0,0,1,0, 1,1);
        addVec(1,0,0,1,0,1,8, 2,0,1,1,0, 1,1);
        addVec(1,0,0,1,0,0,8, 2,0,0,1,0, 1,1);
        addVec(1,0,0,1,0,1,8, 2,0,1,1,0, 1,1);
        addVec(1,0,0,1,1,0,8, 2,0,0,1,1, 1,1);
        addVec(1,0,0,1,1,1,8, 2,0,1,1,1, 1,1);
        addVec(1,0,0,0,0,1,8, 0,0,0,0,0, 1,2);
        // Both requesters hold single-beat packets continuously.
        addVec(1,1,1,1,1,1,8, 0,0,0,0,0, 1,2);
        addVec(1,1,1,1,1,1,8, 1,1,0,1,1, 1,2);
        addVec(1,1,1,1,1,1,8, 0,0,0,0,0, 2,2);
        addVec(1,1,1,1,1,1,8, PRIO ? 1 : 2, PRIO, !PRIO, 1,1, 2,2);
        addVec(1,1,1,1,1,1,8, 0,0,0,0,0, PRIO ? 3 : 2, PRIO ? 2 : 3);
        addVec(1,1,1,1,1,1,8, 1,1,0,1,1, PRIO ? 3 : 2, PRIO ? 2 : 3);
        addVec(1,1,1,1,1,1,8, 0,0,0,0,0, PRIO ? 4 : 3, PRIO ? 2 : 3);
        addVec(1,1,1,1,1,1,8, PRIO ? 1 : 2, PRIO, !PRIO, 1,1, PRIO ? 4 : 3, PRIO ? 2 : 3);
        addVec(1,0,0,0,0,1,8, 0,0,0,0,0, PRIO ? 5 : 3, PRIO ? 2 : 4);
        // rq0 stalls mid-packet while rq1 requests; ownership must not move.
        addVec(1,1,0,0,0,1,8, 0,0,0,0,0, PRIO ? 5 : 3, PRIO ? 2 : 4);
        addVec(1,1,0,0,0,1,8, 1,1,0,1,0, PRIO ? 5 : 3, PRIO ? 2 : 4);
        addVec(1,0,0,1,1,1,8, 1,1,0,0,0, PRIO ? 5 : 3, PRIO ? 2 : 4);
        addVec(1,1,1,1,1,1,8, 1,1,0,1,1, PRIO ? 5 : 3, PRIO ? 2 : 4);
        // Reset during beat 2 abandons the packet and restores the tie pointer.
        addVec(1,1,0,0,0,1,8, 0,0,0,0,0, PRIO ? 6 : 4, PRIO ? 2 : 4);
        addVec(1,1,0,0,0,1,8, 1,1,0,1,0, PRIO ? 6 : 4, PRIO ? 2 : 4);
        addVec(0,1,0,0,0,1,8, 1,1,0,1,0, PRIO ? 6 : 4, PRIO ? 2 : 4);
        addVec(1,1,1,1,1,1,8, 0,0,0,0,0, 0,0);
        addVec(1,1,1,1,1,1,8, 1,1,0,1,1, 0,0);
        addVec(1,0,0,0,0,1,8, 0,0,0,0,0, 1,0);

        rst_n = 1'b0;
        rq0_tvalid = 1'b0; rq0_tlast = 1'b0; rq0_tdata = '0; rq0_tkeep = '0;
        rq1_tvalid = 1'b0; rq1_tlast = 1'b0; rq1_tdata = '0; rq1_tkeep = '0;
        s_axis_tx_tready = 1'b0;
        tx_buf_av = 6'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k], k);
            #1;
            checkOutput(vecs[k], k);
            @(posedge clk); #1;
        end

        sendPacket(1, 5);
        sendPacket(0, 4);
        checkValue("grant after random packets", 32'(grant), 32'd0);
        checkValue("pkt_cnt0 after random packets", 32'(pkt_cnt0), 32'd2);
        checkValue("pkt_cnt1 after random packets", 32'(pkt_cnt1), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        checkValue("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arbiter.md
PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 SHALL have parameter: MIN_BUF_AV, default 2, minimum core tx_buf_av needed to start a packet.
REQ-002 SHALL have clock and reset:
  clk  in  1  rising-edge clock.
  rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have requester ports, n = 0 (completion engine) and 1 (DMA write engine):
  rqn_tdata  in  128  TLP beat.
  rqn_tkeep  in  16  byte enables.
  rqn_tlast  in  1  last beat of TLP.
  rqn_tvalid  in  1  beat valid.
  rqn_tready  out  1  beat accepted.
REQ-004 SHALL have core ports:
  s_axis_tx_tdata  out  128  muxed beat.
  s_axis_tx_tstrb  out  16  muxed rqn_tkeep.
  s_axis_tx_tlast  out  1  muxed tlast.
  s_axis_tx_tvalid  out  1  muxed tvalid.
  s_axis_tx_tready  in  1  core ready.
  s_axis_tx_tuser  out  4  tied 0.
  tx_buf_av  in  6  free core TX buffers.
  grant  out  2  one-hot owner; 0 when idle.
  pkt_cnt0, pkt_cnt1  out  16  completed-TLP counts per requester.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY0, BUSY1.
REQ-006 IDLE: grant=0; both rqn_tready=0; s_axis_tx_tvalid=0.
REQ-007 IDLE->BUSYn next cycle when rqn_tvalid=1, tx_buf_av>=MIN_BUF_AV and requester n wins arbitration (REQ-009/REQ-016); stay IDLE otherwise.
REQ-008 BUSYn: grant[n]=1; s_axis_tx_* = rqn_* combinationally (zero latency); rqn_tready = s_axis_tx_tready; other requester's tready=0.
REQ-009 Round-robin on simultaneous requests: grant the requester not served by the last completed packet; single request: grant it.
REQ-010 BUSYn->IDLE on the cycle rqn_tvalid & s_axis_tx_tready & rqn_tlast; every packet is followed by exactly one IDLE cycle.
REQ-011 Ownership is held for the whole packet; no interleaving. tvalid deassertion mid-packet holds BUSYn.
REQ-012 tx_buf_av is sampled only in IDLE; a drop mid-packet does not stall the arbiter.
REQ-013 pkt_cntn increments by 1 on each REQ-010 exit from BUSYn; wraps 0xFFFF->0x0000.
REQ-014 The last-served pointer updates on the REQ-010 exit, not on grant.

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE, grant=0, all tready/tvalid=0, pkt_cnt0=pkt_cnt1=0 and last-served=1 (requester 0 wins first tie); a packet in flight is abandoned and not counted.

Configuration
REQ-016 Macro PCIE_TX_CPL_PRIORITY_EN defined: requester 0 wins strict priority in IDLE whenever rq0_tvalid=1; last-served pointer ignored. Undefined: round-robin per REQ-009.
REQ-017 Either build SHALL keep identical ports and FSM.

Verification
REQ-018 rq0 sends 3-beat TLP, rq1 idle, tx_buf_av=8 -> grant=01 one cycle later, 3 beats pass unchanged, IDLE for 1 cycle, pkt_cnt0=1.
REQ-019 rq0 and rq1 both request continuously (macro undefined) -> grant sequence 01,10,01,10; each packet separated by one IDLE cycle.
REQ-020 Same stimulus with PCIE_TX_CPL_PRIORITY_EN defined -> grant stays 01 for all packets; rq1 is never granted.
REQ-021 tx_buf_av=1 with rq1 requesting -> stays IDLE; tx_buf_av=2 -> BUSY1 next cycle; tx_buf_av drops to 0 mid-packet -> packet completes.
REQ-022 s_axis_tx_tready toggles 1,0,1,0 during a 4-beat rq1 TLP -> rq1_tready mirrors it, no beat lost or duplicated, tlast on beat 4 only.
REQ-023 rst_n=0 during beat 2 of an rq0 packet -> next cycle IDLE, grant=0, pkt_cnt0=0; the next tie goes to rq0.
